// File: rtl/jtag_pkg.sv
// Shared encodings and step counts for the JTAG initiator.
// Step counts cover the fixed TMS prefix/suffix around each shift.
package jtag_pkg;

    typedef enum logic [1:0] {
        OP_TAPRESET = 2'b00,
        OP_IRSCAN   = 2'b01,
        OP_DRSCAN   = 2'b10,
        OP_NOP      = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FINISH
    } state_e;

    localparam int IR_PREFIX   = 4;
    localparam int DR_PREFIX   = 3;
    localparam int SUFFIX      = 2;
    localparam int RESET_STEPS = 6;

endpackage

// File: rtl/jtag_if.sv
// Command handshake between the test controller and the JTAG initiator.
// master = controller side, slave = jtag_master side.
interface jtag_if #(
    parameter int DR_WIDTH = 32
) ();

    logic                start;
    logic [1:0]          op;
    logic [DR_WIDTH-1:0] shift_in;
    logic [DR_WIDTH-1:0] shift_out;
    logic                busy;
    logic                done;

    modport master (
        output start, op, shift_in,
        input  shift_out, busy, done
    );

    modport slave (
        input  start, op, shift_in,
        output shift_out, busy, done
    );

endinterface

// File: rtl/jtag_tck_gen.sv
// TCK divider: TCK_DIV clocks per half period, low half first.
// Strobes flag the cycle before TCK rises or falls.
module jtag_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic tck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tck_q, tck_d;
    logic          wrap;

    assign wrap   = en_i && (cnt_q == CW'(TCK_DIV - 1));
    assign rise_o = wrap && !tck_q;
    assign fall_o = wrap && tck_q;
    assign tck_o  = tck_q;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        tck_d = tck_q;
        if (!en_i) begin
            cnt_d = '0;
            tck_d = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            tck_d = ~tck_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tck_q <= tck_d;
        end
    end

endmodule

// File: rtl/jtag_master.sv
// JTAG initiator: runs one TapReset / IR scan / DR scan at a time,
// starting and ending in Run-Test/Idle.
module jtag_master
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH = 4,
    parameter int DR_WIDTH = 32,
    parameter int TCK_DIV  = 2
) (
    input  logic   clk_i,
    input  logic   rst_i,
    jtag_if.slave  cmd,
    output logic   tck_o,
    output logic   tms_o,
    output logic   tdi_o,
    input  logic   tdo_i
);

    localparam int SW = $clog2(DR_WIDTH + 8);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [DR_WIDTH-1:0] data_q, data_d;
    logic [DR_WIDTH-1:0] sout_q, sout_d;
    logic [SW-1:0]       step_q, step_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tck_rise, tck_fall;
    int                  idx;

    function automatic int pre_len(op_e op);
        return (op == OP_IRSCAN) ? IR_PREFIX : DR_PREFIX;
    endfunction

    function automatic int sh_len(op_e op);
        return (op == OP_IRSCAN) ? IR_WIDTH : DR_WIDTH;
    endfunction

    function automatic logic [SW-1:0] last_step(op_e op);
        if (op == OP_TAPRESET) return SW'(RESET_STEPS - 1);
        return SW'(pre_len(op) + sh_len(op) + SUFFIX - 1);
    endfunction

    // {TMS, TDI} presented during step s
    function automatic logic [1:0] pins(
        op_e op, logic [SW-1:0] s, logic [DR_WIDTH-1:0] d
    );
        int i, p, w;
        logic [DR_WIDTH-1:0] sh;
        i  = int'(s);
        p  = pre_len(op);
        w  = sh_len(op);
        sh = d >> (i - p);
        if (op == OP_TAPRESET) return {i < RESET_STEPS - 1, 1'b0};
        if (i < p) return {(op == OP_IRSCAN) ? (i < 2) : (i == 0), 1'b0};
        if (i < p + w) return {i == p + w - 1, sh[0]};
        return {i == p + w, 1'b0};
    endfunction

    jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (state_q == S_RUN),
        .tck_o  (tck_o),
        .rise_o (tck_rise),
        .fall_o (tck_fall)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        sout_d  = sout_q;
        step_d  = step_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        idx     = int'(step_q) - pre_len(op_q);
        unique case (state_q)
            S_IDLE: begin
                if (cmd.start) begin
                    if (op_e'(cmd.op) == OP_NOP) begin
                        done_d = 1'b1;
                    end else begin
                        state_d        = S_RUN;
                        op_d           = op_e'(cmd.op);
                        data_d         = cmd.shift_in;
                        sout_d         = '0;
                        step_d         = '0;
                        busy_d         = 1'b1;
                        {tms_d, tdi_d} = pins(op_e'(cmd.op), '0, cmd.shift_in);
                    end
                end
            end
            S_RUN: begin
                // TCK falling ends the step: sample TDO, then advance
                if (tck_fall) begin
                    if (op_q != OP_TAPRESET && idx >= 0 && idx < sh_len(op_q))
                        sout_d = sout_q | (DR_WIDTH'(tdo_i) << idx);
                    if (step_q == last_step(op_q)) begin
                        state_d = S_FINISH;
                        tms_d   = 1'b0;
                        tdi_d   = 1'b0;
                    end else begin
                        step_d         = step_q + 1'b1;
                        {tms_d, tdi_d} = pins(op_q, step_q + 1'b1, data_q);
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            sout_q  <= '0;
            step_q  <= '0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            sout_q  <= sout_d;
            step_q  <= step_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (rst_i) tck_rise |-> !tck_o);

    assign tms_o         = tms_q;
    assign tdi_o         = tdi_q;
    assign cmd.busy      = busy_q;
    assign cmd.done      = done_q;
    assign cmd.shift_out = sout_q;

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: behavioural TAP with 4-bit IR (capture 0101)
// and a plain DR, driven by two DUTs (TCK_DIV 2 and 1) through a mux.
module tb_jtag_master;
    import jtag_pkg::*;

    localparam int IRW = 4;
    localparam int DRW = 32;

    typedef enum int {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR
    } tap_e;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jtag_if #(.DR_WIDTH(DRW)) c0 ();
    jtag_if #(.DR_WIDTH(DRW)) c1 ();

    logic tck0, tms0, tdi0, tck1, tms1, tdi1;
    logic tck_m, tms_m, tdi_m, tdo_m;
    bit   sel = 1'b0;

    assign tck_m = sel ? tck1 : tck0;
    assign tms_m = sel ? tms1 : tms0;
    assign tdi_m = sel ? tdi1 : tdi0;

    jtag_master #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_DIV(2)) dut0 (
        .clk_i(clk), .rst_i(rst), .cmd(c0),
        .tck_o(tck0), .tms_o(tms0), .tdi_o(tdi0), .tdo_i(tdo_m)
    );

    jtag_master #(.IR_WIDTH(IRW), .DR_WIDTH(DRW), .TCK_DIV(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .cmd(c1),
        .tck_o(tck1), .tms_o(tms1), .tdi_o(tdi1), .tdo_i(tdo_m)
    );

    // behavioural TAP
    tap_e           st = TLR;
    logic [IRW-1:0] ir = '0, irsr = '0;
    logic [DRW-1:0] drsr = '0, dr_upd = '0;
    logic [DRW-1:0] dr_cap = '0;
    bit             tms_hist [4096];
    bit             tdi_hist [4096];
    int             rise_cnt = 0;
    initial tdo_m = 1'b0;

    function automatic tap_e tap_next(tap_e s, logic t);
        case (s)
            TLR:     return t ? TLR   : RTI;
            RTI:     return t ? SELDR : RTI;
            SELDR:   return t ? SELIR : CAPDR;
            CAPDR:   return t ? EX1DR : SHDR;
            SHDR:    return t ? EX1DR : SHDR;
            EX1DR:   return t ? UPDR  : PDR;
            PDR:     return t ? EX2DR : PDR;
            EX2DR:   return t ? UPDR  : SHDR;
            UPDR:    return t ? SELDR : RTI;
            SELIR:   return t ? TLR   : CAPIR;
            CAPIR:   return t ? EX1IR : SHIR;
            SHIR:    return t ? EX1IR : SHIR;
            EX1IR:   return t ? UPIR  : PIR;
            PIR:     return t ? EX2IR : PIR;
            EX2IR:   return t ? UPIR  : SHIR;
            default: return t ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck_m) begin
        tms_hist[rise_cnt % 4096] = tms_m;
        tdi_hist[rise_cnt % 4096] = tdi_m;
        rise_cnt = rise_cnt + 1;
        case (st)
            CAPIR:   irsr = 4'b0101;
            SHIR:    irsr = {tdi_m, irsr[IRW-1:1]};
            UPIR:    ir = irsr;
            CAPDR:   drsr = dr_cap;
            SHDR:    drsr = {tdi_m, drsr[DRW-1:1]};
            UPDR:    dr_upd = drsr;
            default: ;
        endcase
        st = tap_next(st, tms_m);
    end

    always @(negedge tck_m)
        tdo_m = (st == SHIR) ? irsr[0] : (st == SHDR) ? drsr[0] : 1'b0;

    // spec-level expectations
    int n_pass = 0;
    int n_chk  = 0;

    function automatic int n_steps(logic [1:0] op);
        case (op)
            OP_TAPRESET: return 6;
            OP_IRSCAN:   return IRW + 6;
            OP_DRSCAN:   return DRW + 5;
            default:     return 0;
        endcase
    endfunction

    function automatic int lat(logic [1:0] op, int div);
        return (op == OP_NOP) ? 0 : n_steps(op) * 2 * div + 1;
    endfunction

    function automatic logic [63:0] exp_tms(logic [1:0] op);
        logic [63:0] v;
        logic [3:0]  pre;
        int n, p, w;
        v   = '0;
        n   = n_steps(op);
        p   = (op == OP_IRSCAN) ? 4 : 3;
        w   = (op == OP_IRSCAN) ? IRW : DRW;
        pre = (op == OP_IRSCAN) ? 4'b0011 : 4'b0001;
        for (int i = 0; i < n; i++) begin
            if (op == OP_TAPRESET) v[i] = (i < 5);
            else if (i < p)        v[i] = pre[i];
            else if (i < p + w)    v[i] = (i == p + w - 1);
            else                   v[i] = (i == p + w);
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_tdi(logic [1:0] op, logic [DRW-1:0] d);
        logic [63:0] v;
        int n, p, w;
        v = '0;
        n = n_steps(op);
        p = (op == OP_IRSCAN) ? 4 : 3;
        w = (op == OP_IRSCAN) ? IRW : DRW;
        for (int i = 0; i < n; i++)
            if (op != OP_TAPRESET && i >= p && i < p + w) v[i] = d[i-p];
        return v;
    endfunction

    task automatic drive(bit u, logic s, logic [1:0] op, logic [DRW-1:0] d);
        if (u) begin
            c1.start = s; c1.op = op; c1.shift_in = d;
        end else begin
            c0.start = s; c0.op = op; c0.shift_in = d;
        end
    endtask

    // issue one command and watch it for win cycles after the Start edge
    task automatic run(
        input bit u, input logic [1:0] op, input logic [DRW-1:0] d,
        input int win, input int gk,
        output int dk, output int nd, output bit bok, output int nr,
        output logic [63:0] at, output logic [63:0] ad
    );
        int base;
        logic b, dn;
        logic [1:0] gop;
        gop = (op == OP_IRSCAN) ? OP_TAPRESET : OP_IRSCAN;
        @(posedge clk); #1;
        drive(u, 1'b1, op, d);
        base = rise_cnt;
        @(posedge clk); #1;
        drive(u, 1'b0, op, d);
        dk = -1; nd = 0; bok = 1'b1;
        for (int k = 0; k <= win; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == gk) drive(u, 1'b1, gop, ~d);
            if (k == gk + 1) drive(u, 1'b0, op, d);
            dn = u ? c1.done : c0.done;
            b  = u ? c1.busy : c0.busy;
            if (dn) begin
                nd++;
                if (dk < 0) dk = k;
            end
            if ((dk < 0) != b) bok = 1'b0;
        end
        nr = rise_cnt - base;
        at = '0; ad = '0;
        for (int i = 0; i < nr && i < 64; i++) begin
            at[i] = tms_hist[(base + i) % 4096];
            ad[i] = tdi_hist[(base + i) % 4096];
        end
    endtask

    int dk, nd, nr;
    bit bok;
    logic [63:0] at, ad;

    task automatic test_reset;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (tck0 !== 1'b0) $display("FAIL rst_tck got %b want 0", tck0); else n_pass++;
        n_chk++; if (tms0 !== 1'b1) $display("FAIL rst_tms got %b want 1", tms0); else n_pass++;
        n_chk++; if (tdi0 !== 1'b0) $display("FAIL rst_tdi got %b want 0", tdi0); else n_pass++;
        n_chk++; if ({c0.busy, c0.done} !== 2'b00) $display("FAIL rst_busy_done got %b want 00", {c0.busy, c0.done}); else n_pass++;
        n_chk++; if (c0.shift_out !== '0) $display("FAIL rst_sout got %h want 0", c0.shift_out); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_tapreset;
        run(0, OP_TAPRESET, $urandom(), 30, -1, dk, nd, bok, nr, at, ad);
        n_chk++; if (dk !== 25) $display("FAIL tr_latency got %0d want 25", dk); else n_pass++;
        n_chk++; if (nd !== 1) $display("FAIL tr_done_cnt got %0d want 1", nd); else n_pass++;
        n_chk++; if (nr !== 6) $display("FAIL tr_rises got %0d want 6", nr); else n_pass++;
        n_chk++; if (at !== 64'h1f) $display("FAIL tr_tms got %h want 1f", at); else n_pass++;
        n_chk++; if (st !== RTI) $display("FAIL tr_tap_state got %0d want %0d", st, RTI); else n_pass++;
        n_chk++; if (!bok) $display("FAIL tr_busy got bad want high-until-done"); else n_pass++;
        n_chk++; if ({tck0, tms0} !== 2'b00) $display("FAIL tr_park got %b want 00", {tck0, tms0}); else n_pass++;
    endtask

    task automatic test_irscan;
        logic [DRW-1:0] d;
        d = ($urandom() & 32'hFFFF_FFF0) | 32'h0000_000A;
        run(0, OP_IRSCAN, d, 45, -1, dk, nd, bok, nr, at, ad);
        n_chk++; if (dk !== 41) $display("FAIL ir_latency got %0d want 41", dk); else n_pass++;
        n_chk++; if (ad !== exp_tdi(OP_IRSCAN, d)) $display("FAIL ir_tdi got %h want %h", ad, exp_tdi(OP_IRSCAN, d)); else n_pass++;
        n_chk++; if (at !== exp_tms(OP_IRSCAN)) $display("FAIL ir_tms got %h want %h", at, exp_tms(OP_IRSCAN)); else n_pass++;
        n_chk++; if (ir !== 4'b1010) $display("FAIL ir_update got %b want 1010", ir); else n_pass++;
        n_chk++; if (c0.shift_out !== 32'h5) $display("FAIL ir_sout got %h want 5", c0.shift_out); else n_pass++;
    endtask

    task automatic test_drscan;
        dr_cap = 32'h1234_5678;
        run(0, OP_DRSCAN, 32'hDEAD_BEEF, 153, -1, dk, nd, bok, nr, at, ad);
        n_chk++; if (c0.shift_out !== 32'h1234_5678) $display("FAIL dr_sout got %h want 12345678", c0.shift_out); else n_pass++;
        n_chk++; if (dr_upd !== 32'hDEAD_BEEF) $display("FAIL dr_update got %h want deadbeef", dr_upd); else n_pass++;
        n_chk++; if (dk !== 149) $display("FAIL dr_latency got %0d want 149", dk); else n_pass++;
        n_chk++; if (!bok) $display("FAIL dr_busy got bad want high-until-done"); else n_pass++;
        n_chk++; if (at !== exp_tms(OP_DRSCAN)) $display("FAIL dr_tms got %h want %h", at, exp_tms(OP_DRSCAN)); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [DRW-1:0] d, cap;
        d = $urandom(); cap = $urandom(); dr_cap = cap;
        run(0, OP_DRSCAN, d, 160, 50, dk, nd, bok, nr, at, ad);
        n_chk++; if (nd !== 1) $display("FAIL b2b_done_cnt got %0d want 1", nd); else n_pass++;
        n_chk++; if (dk !== 149) $display("FAIL b2b_latency got %0d want 149", dk); else n_pass++;
        n_chk++; if (nr !== 37) $display("FAIL b2b_rises got %0d want 37", nr); else n_pass++;
        n_chk++; if (c0.shift_out !== cap) $display("FAIL b2b_sout got %h want %h", c0.shift_out, cap); else n_pass++;
        n_chk++; if (dr_upd !== d) $display("FAIL b2b_update got %h want %h", dr_upd, d); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [DRW-1:0] d;
        bit seen;
        @(posedge clk); #1;
        drive(0, 1'b1, OP_IRSCAN, $urandom());
        @(posedge clk); #1;
        drive(0, 1'b0, OP_IRSCAN, '0);
        repeat (22) @(posedge clk);
        #1;
        n_chk++; if (tck0 !== 1'b1) $display("FAIL mid_pre_tck got %b want 1", tck0); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if ({tck0, tms0, tdi0} !== 3'b010) $display("FAIL mid_pins got %b want 010", {tck0, tms0, tdi0}); else n_pass++;
        n_chk++; if ({c0.busy, c0.done} !== 2'b00) $display("FAIL mid_busy_done got %b want 00", {c0.busy, c0.done}); else n_pass++;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (c0.done) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (c0.done) seen = 1'b1;
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL mid_no_done got %b want 0", seen); else n_pass++;
        run(0, OP_TAPRESET, '0, 30, -1, dk, nd, bok, nr, at, ad);
        n_chk++; if (st !== RTI) $display("FAIL mid_tr_state got %0d want %0d", st, RTI); else n_pass++;
        d = $urandom();
        run(0, OP_IRSCAN, d, 45, -1, dk, nd, bok, nr, at, ad);
        n_chk++; if (ir !== d[IRW-1:0]) $display("FAIL mid_ir got %b want %b", ir, d[IRW-1:0]); else n_pass++;
        n_chk++; if (c0.shift_out !== 32'h5) $display("FAIL mid_ir_sout got %h want 5", c0.shift_out); else n_pass++;
    endtask

    task automatic test_random;
        logic [DRW-1:0] d, cap, so;
        logic [1:0] op;
        for (int n = 0; n < 6; n++) begin
            op  = $urandom_range(0, 1) ? OP_DRSCAN : OP_IRSCAN;
            d   = $urandom();
            cap = $urandom();
            dr_cap = cap;
            so  = (op == OP_IRSCAN) ? 32'h5 : cap;
            run(0, op, d, lat(op, 2) + 4, -1, dk, nd, bok, nr, at, ad);
            n_chk++; if (c0.shift_out !== so) $display("FAIL rnd_sout got %h want %h", c0.shift_out, so); else n_pass++;
            n_chk++; if (dk !== lat(op, 2)) $display("FAIL rnd_latency got %0d want %0d", dk, lat(op, 2)); else n_pass++;
            n_chk++; if (ad !== exp_tdi(op, d)) $display("FAIL rnd_tdi got %h want %h", ad, exp_tdi(op, d)); else n_pass++;
            if (op == OP_IRSCAN) begin
                n_chk++; if (ir !== d[IRW-1:0]) $display("FAIL rnd_ir got %b want %b", ir, d[IRW-1:0]); else n_pass++;
            end else begin
                n_chk++; if (dr_upd !== d) $display("FAIL rnd_dr got %h want %h", dr_upd, d); else n_pass++;
            end
        end
    endtask

    task automatic test_div1;
        logic [DRW-1:0] d, cap;
        sel = 1'b1;
        d = $urandom(); cap = $urandom(); dr_cap = cap;
        run(1, OP_DRSCAN, d, 80, -1, dk, nd, bok, nr, at, ad);
        n_chk++; if (c1.shift_out !== cap) $display("FAIL d1_sout got %h want %h", c1.shift_out, cap); else n_pass++;
        n_chk++; if (dr_upd !== d) $display("FAIL d1_update got %h want %h", dr_upd, d); else n_pass++;
        n_chk++; if (dk !== lat(OP_DRSCAN, 1)) $display("FAIL d1_latency got %0d want %0d", dk, lat(OP_DRSCAN, 1)); else n_pass++;
        run(1, OP_NOP, $urandom(), 6, -1, dk, nd, bok, nr, at, ad);
        n_chk++; if (dk !== 0) $display("FAIL nop_latency got %0d want 0", dk); else n_pass++;
        n_chk++; if (nd !== 1) $display("FAIL nop_done_cnt got %0d want 1", nd); else n_pass++;
        n_chk++; if (nr !== 0) $display("FAIL nop_tck got %0d rises want 0", nr); else n_pass++;
        n_chk++; if (!bok) $display("FAIL nop_busy got high want low"); else n_pass++;
        sel = 1'b0;
    endtask

    initial begin
        drive(0, 1'b0, OP_NOP, '0);
        drive(1, 1'b0, OP_NOP, '0);
        test_reset();
        test_tapreset();
        test_irscan();
        test_drscan();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_div1();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
